io_debounce: RTL and testbench
==============================

// Module: io_debounce
// PURPOSE
//  Input conditioner between the board pins and the core's sw/btn ports, feeding the LSU input map.
//  Synchronises raw switch/button levels to clk and debounces every bit with a shared tick prescaler.
//  Produces clean levels plus one-cycle press pulses and software-clearable sticky press flags.
// PARAMETERS
//  WIDTH          32     bits per input word (sw and btn)
//  TICK_DIV       50000  clk cycles per debounce tick (1 ms at 50 MHz); >=2
//  STABLE_TICKS   10     consecutive ticks a new level must hold before acceptance; >=1
//  BTN_ACTIVE_LOW 1      1: raw buttons are low when pressed; inverted internally
// PORTS
//  clk        in   1      system clock, the core's single clock domain
//  rst        in   1      synchronous, active-high reset
//  sw_raw     in   WIDTH  asynchronous switch pins
//  btn_raw    in   WIDTH  asynchronous button pins, polarity per BTN_ACTIVE_LOW
//  btn_clr    in   WIDTH  per-bit clear of btn_sticky, write-1-to-clear, one-cycle strobe from LSU
//  sw         out  WIDTH  debounced switch levels -> core sw
//  btn        out  WIDTH  debounced button levels, 1 = pressed -> core btn
//  btn_press  out  WIDTH  1-cycle pulse on each debounced 0->1 of btn
//  btn_sticky out  WIDTH  latched press flags, held until cleared
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): prescaler=0, all debounce counters=0, sw=0, btn=0,
//    btn_press=0, btn_sticky=0; btn sync flops load the released level (1 if BTN_ACTIVE_LOW),
//    sw sync flops load 0, so no spurious press/edge follows reset release.
//  - Sync: 2-flop synchroniser per bit; btn inverted after sync when BTN_ACTIVE_LOW=1.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps; tick=1 for the single cycle count==TICK_DIV-1.
//  - Per bit (sync s, stable q, counter c, width $clog2(STABLE_TICKS+1)):
//      s==q                 -> c<=0 on that cycle (any glitch restarts qualification)
//      s!=q, tick, c<STABLE_TICKS-1 -> c<=c+1
//      s!=q, tick, c==STABLE_TICKS-1 -> q<=s, c<=0
//      s!=q, no tick        -> hold
//  - Latency pin->output: 2 sync cycles + between (STABLE_TICKS-1)*TICK_DIV+1 and
//    STABLE_TICKS*TICK_DIV cycles. Pulses shorter than (STABLE_TICKS-1)*TICK_DIV are never passed.
//  - btn_press[i] registered: high exactly the cycle after btn[i] goes 0->1; never on 1->0.
//  - btn_sticky[i]: set when btn_press[i]=1, cleared when btn_clr[i]=1; both same cycle -> stays 1
//    (press is never lost). btn_clr on a bit already 0 has no effect.
//  - Sw bits are debounced identically but generate no press/sticky.
//  - rst asserted mid-qualification discards the pending change; the level re-qualifies from 0.
//  - No wrap hazards: counters saturate by rule above and never exceed STABLE_TICKS-1.
// STRUCTURE
//  - io_pkg: default constants (DEF_TICK_DIV, DEF_STABLE_TICKS, DEF_WIDTH) shared with LSU/top.
//  - Sub-module debounce_bit (sync pair + counter + stable flop, RESET_LEVEL param),
//    instantiated 2*WIDTH times via generate; prescaler, edge detect and sticky logic live here.
// TESTING (bench params TICK_DIV=4, STABLE_TICKS=3, BTN_ACTIVE_LOW=1)
//  - Reset: rst=1 2 cycles, btn_raw=all 1s, sw_raw=0 -> all outputs 0, no btn_press for 50 cycles.
//  - Clean press: btn_raw[0] 1->0 held -> btn[0]=1 within 2+9..2+12 cycles; btn_press[0] high 1 cycle.
//  - Glitch reject: btn_raw[1] low for 6 cycles then high -> btn[1], btn_press[1], btn_sticky[1] stay 0.
//  - Bounce: sw_raw[5] toggles every 3 cycles for 30 cycles then holds 1 -> single 0->1 on sw[5],
//    no intermediate transitions.
//  - Sticky: press btn[2], then btn_clr[2]=1 on same cycle as second btn_press[2] -> sticky stays 1;
//    next btn_clr[2] alone -> 0.
//  - Reset mid-qualify: btn_raw[3] low, rst pulse after 7 cycles -> btn[3]=0, re-asserts full latency later.

Source files
------------

// File: rtl/io_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_pkg : default constants for the pin-input conditioner, shared with LSU/top
// Rev 1.0
// ---------------------------------------------------------------------------
package io_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 10;

  // Width of a qualification counter able to hold 0..stable_ticks.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce_bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_bit : 2-flop synchroniser plus tick-qualified stable level, one bit
// Rev 1.0
// ---------------------------------------------------------------------------
module debounce_bit
  import io_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit RESET_LEVEL  = 1'b0,
  parameter bit INVERT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int             CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_level;

  assign w_level = r_sync ^ INVERT;

  // Sync flops reset to the idle pin level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta   <= RESET_LEVEL;
      r_sync   <= RESET_LEVEL;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      if (w_level == r_stable) begin
        r_cnt <= '0;
      end else if (tick) begin
        if (r_cnt == LAST) begin
          r_stable <= w_level;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_debounce : sync + debounce of sw/btn pins, press pulses and sticky flags
// Rev 1.0
// ---------------------------------------------------------------------------
module io_debounce
  import io_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int STABLE_TICKS   = DEF_STABLE_TICKS,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic [WIDTH-1:0] btn_clr,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_sticky
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam bit            BTN_INV    = (BTN_ACTIVE_LOW != 0);

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [WIDTH-1:0] w_btn;
  logic [WIDTH-1:0] r_btn_d;
  logic [WIDTH-1:0] r_press;
  logic [WIDTH-1:0] r_sticky;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (1'b0),
      .INVERT      (1'b0)
    ) u_sw (
      .clk   (clk),
      .rst   (rst),
      .tick  (w_tick),
      .raw   (sw_raw[i]),
      .stable(sw[i])
    );

    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (BTN_INV),
      .INVERT      (BTN_INV)
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .tick  (w_tick),
      .raw   (btn_raw[i]),
      .stable(w_btn[i])
    );
  end

  // A clear arriving with a press keeps the flag set, so no press is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_d  <= '0;
      r_press  <= '0;
      r_sticky <= '0;
    end else begin
      r_btn_d  <= w_btn;
      r_press  <= w_btn & ~r_btn_d;
      r_sticky <= (r_sticky & ~btn_clr) | r_press;
    end
  end

  assign btn        = w_btn;
  assign btn_press  = r_press;
  assign btn_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_io_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_io_debounce : vector table, corner sequences and random run vs. a model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_io_debounce;

  localparam int W  = 32;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw, btn_raw, btn_clr;
  logic [W-1:0] sw, btn, btn_press, btn_sticky;

  always #5 clk = ~clk;

  io_debounce #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw), .btn_clr(btn_clr),
    .sw(sw), .btn(btn), .btn_press(btn_press), .btn_sticky(btn_sticky)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_btn(input int idx, input logic val, input int budget, output int cyc);
    cyc = 0;
    while (btn[idx] !== val && cyc < budget) begin
      cycle();
      cyc++;
    end
  endtask

  // Reference model: a level is accepted once ST prescaler ticks have
  // elapsed while the synchronised input continuously differed from it.
  logic         model_on = 1'b0;
  int           n;
  int           start_sw [W];
  int           start_btn[W];
  logic [W-1:0] d1_sw, d2_sw, d1_btn, d2_btn;
  logic [W-1:0] m_sw, m_btn, m_btn_prev, m_press, m_sticky;

  function automatic int ticks_in(input int after_cyc, input int upto_cyc);
    return (upto_cyc + 1) / TD - (after_cyc + 1) / TD;
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] s_sw, s_btn, nq_sw, nq_btn;
    logic         tick;
    if (rst) begin
      n = 0;
      d1_sw = '0; d2_sw = '0; d1_btn = '1; d2_btn = '1;
      m_sw = '0; m_btn = '0; m_btn_prev = '0; m_press = '0; m_sticky = '0;
      for (int i = 0; i < W; i++) begin
        start_sw[i]  = -1;
        start_btn[i] = -1;
      end
    end else begin
      tick   = (n % TD) == TD - 1;
      s_sw   = d2_sw;
      s_btn  = ~d2_btn;
      nq_sw  = m_sw;
      nq_btn = m_btn;
      for (int i = 0; i < W; i++) begin
        if (s_sw[i] == m_sw[i]) start_sw[i] = n;
        else if (tick && ticks_in(start_sw[i], n) >= ST) begin
          nq_sw[i] = s_sw[i];
          start_sw[i] = n;
        end
        if (s_btn[i] == m_btn[i]) start_btn[i] = n;
        else if (tick && ticks_in(start_btn[i], n) >= ST) begin
          nq_btn[i] = s_btn[i];
          start_btn[i] = n;
        end
      end
      m_sticky   = (m_sticky & ~btn_clr) | m_press;
      m_press    = m_btn & ~m_btn_prev;
      m_btn_prev = m_btn;
      m_btn      = nq_btn;
      m_sw       = nq_sw;
      d2_sw = d1_sw; d1_sw = sw_raw;
      d2_btn = d1_btn; d1_btn = btn_raw;
      n++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_sw", sw, m_sw);
      chk("model_btn", btn, m_btn);
      chk("model_press", btn_press, m_press);
      chk("model_sticky", btn_sticky, m_sticky);
    end
  end

  typedef struct {
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] btn_raw;
    logic [W-1:0] btn_clr;
    logic [W-1:0] exp_sw;
    logic [W-1:0] exp_btn;
    logic [W-1:0] exp_press;
    logic [W-1:0] exp_sticky;
  } vec_t;

  initial begin
    vec_t         tbl[6];
    int           cyc;
    int           rises, falls;
    logic         prev, seen;
    int           idx;

    rst = 1'b1; sw_raw = '0; btn_raw = '1; btn_clr = '0;

    tbl[0] = '{1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[5] = '{1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    cycle();
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst; sw_raw = tbl[i].sw_raw;
      btn_raw = tbl[i].btn_raw; btn_clr = tbl[i].btn_clr;
      cycle();
      chk("tbl_sw", sw, tbl[i].exp_sw);
      chk("tbl_btn", btn, tbl[i].exp_btn);
      chk("tbl_press", btn_press, tbl[i].exp_press);
      chk("tbl_sticky", btn_sticky, tbl[i].exp_sticky);
    end
    model_on = 1'b1;

    for (int i = 0; i < 50; i++) begin
      cycle();
      chk("reset_no_press", btn_press, '0);
    end

    // Clean press and release on btn[0]
    btn_raw[0] = 1'b0;
    wait_btn(0, 1'b1, 30, cyc);
    chk_rng("press0_latency", cyc, 11, 14);
    cycle();
    chk("press0_pulse", btn_press, 32'h1);
    cycle();
    chk("press0_single", btn_press, 32'h0);
    chk("sticky0_set", btn_sticky, 32'h1);
    btn_raw[0] = 1'b1;
    wait_btn(0, 1'b0, 30, cyc);
    chk_rng("release0_latency", cyc, 11, 14);
    cycle();
    chk("release0_no_press", btn_press, 32'h0);
    btn_clr = 32'h1;
    cycle();
    btn_clr = '0;
    chk("sticky0_clr", btn_sticky, 32'h0);

    // Glitch shorter than the qualification window on btn[1]
    seen = 1'b0;
    btn_raw[1] = 1'b0;
    for (int i = 0; i < 46; i++) begin
      if (i == 6) btn_raw[1] = 1'b1;
      cycle();
      seen = seen | btn[1] | btn_press[1] | btn_sticky[1];
    end
    chk("glitch1_rejected", {31'b0, seen}, 32'h0);

    // Bouncing switch on sw[5]
    rises = 0; falls = 0; prev = sw[5];
    for (int k = 0; k < 11; k++) begin
      sw_raw[5] = (k == 10) ? 1'b1 : ~sw_raw[5];
      for (int j = 0; j < ((k == 10) ? 25 : 3); j++) begin
        cycle();
        if (sw[5] && !prev) rises++;
        if (!sw[5] && prev) falls++;
        prev = sw[5];
      end
    end
    chk_rng("bounce5_rises", rises, 1, 1);
    chk_rng("bounce5_falls", falls, 0, 0);
    chk("bounce5_final", sw & 32'h20, 32'h20);

    // Sticky set/clear interplay on btn[2]
    btn_raw[2] = 1'b0;
    wait_btn(2, 1'b1, 30, cyc);
    chk_rng("press2_latency", cyc, 11, 14);
    cycle();
    cycle();
    chk("sticky2_set", btn_sticky, 32'h4);
    btn_clr = 32'h4;
    cycle();
    btn_clr = '0;
    chk("sticky2_clr", btn_sticky, 32'h0);
    btn_raw[2] = 1'b1;
    wait_btn(2, 1'b0, 30, cyc);
    btn_raw[2] = 1'b0;
    wait_btn(2, 1'b1, 30, cyc);
    chk_rng("press2b_latency", cyc, 11, 14);
    cycle();
    chk("press2b_pulse", btn_press, 32'h4);
    btn_clr = 32'h4;
    cycle();
    btn_clr = '0;
    chk("sticky2_clr_with_press", btn_sticky, 32'h4);
    btn_clr = 32'h4;
    cycle();
    btn_clr = '0;
    chk("sticky2_clr_alone", btn_sticky, 32'h0);
    btn_raw[2] = 1'b1;
    wait_btn(2, 1'b0, 30, cyc);

    // Reset in the middle of qualifying btn[3]
    btn_raw[3] = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_btn", btn, 32'h0);
    wait_btn(3, 1'b1, 30, cyc);
    chk_rng("rst_requalify3", cyc, 11, 14);
    btn_raw[3] = 1'b1;
    wait_btn(3, 1'b0, 30, cyc);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) == 0) begin
        idx = $urandom_range(W - 1);
        sw_raw[idx] = ~sw_raw[idx];
      end
      if ($urandom_range(9) == 0) begin
        idx = $urandom_range(W - 1);
        btn_raw[idx] = ~btn_raw[idx];
      end
      btn_clr = ($urandom_range(7) == 0) ? W'($urandom) : '0;
      rst = (i == 700);
      cycle();
    end
    rst = 1'b0;
    btn_clr = '0;
    cycle();
    model_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
